quickq_top: RTL and testbench
=============================

# quickq_top

Sorted-array priority queue core (QuickQ, top level) holding up to W key/value entries of type kv_t, with the minimum key always at the head. It accepts one enqueue, dequeue or replace command at a time through a ready/acknowledge handshake. It reports occupancy through full/empty flags and exposes the current head and the most recently removed entry. It sits between the scheduler's command logic and its consumers as the single priority-ordering element.

## Interface
- W, 8: capacity in entries; even, ≥2.
- kv_t (from pq_pkg): 32-bit packed {val[15:0], key[15:0]}, key in the LSBs. Ordering uses key only; smaller key = higher priority.
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enq  in  1  insert lt_i.
- deq  in  1  remove head.
- repl  in  1  remove head and insert lt_i as one operation.
- lt_i  in  kv_t  entry to insert for enq/repl.
- rt_i  in  kv_t  reserved; ignored.
- lt_o  out  kv_t  current head (minimum key); 0 when empty.
- rt_o  out  kv_t  entry removed by the last completed deq/repl; holds its value otherwise.
- enq_o, deq_o, repl_o  out  1 each  one-cycle acknowledge when the respective operation completes.
- full_t  out  1  count == W.
- empty_t  out  1  count == 0.
- rdy_t  out  1  idle; a command can be accepted.

## Operation
- Storage: e[0..W-1] sorted ascending by key, plus count (0..W). e[0] is the head. Entries at index ≥ count are don't-care; drive them to 0.
- Command select: when more than one command is asserted, the priority is repl > deq > enq. The others are dropped.
- enq: if not full, insert lt_i after all entries with key ≤ lt_i.key, so equal keys keep FIFO order. count+1.
- deq: if not empty, rt_o ← e[0]; shift e[1..] down by one; count−1.
- repl: if not empty, rt_o ← e[0], then insert lt_i into the remaining entries using the enq rule; count is unchanged. Repl is legal when full.
- Illegal commands (enq when full, deq or repl when empty) are still accepted and take the busy cycle. Storage, count and rt_o do not change, and no ack is issued.
- FSM states:
  - IDLE: rdy_t = 1. A command sampled at a rising edge is latched together with lt_i, and the FSM moves to BUSY.
  - BUSY: rdy_t = 0. On the next edge the FSM updates storage, count and rt_o, pulses the matching ack, and returns to IDLE.
- Commands presented while rdy_t = 0 are ignored.
- lt_o, full_t and empty_t are registered copies of e[0], count == W and count == 0. They update on the same edge as the storage.

## Timing
- Reset (rst = 0, asynchronous): storage = 0, count = 0, FSM = IDLE, lt_o = 0, rt_o = 0, enq_o = deq_o = repl_o = 0, full_t = 0, empty_t = 1, rdy_t = 1.
- Latency:
  - Edge 0 accepts the command; rdy_t is low for the cycle after it.
  - Edge 1 applies the result; the ack is high and rdy_t is high for the cycle after it.
  - The earliest next command is accepted at edge 2.
- Throughput: one operation per 2 cycles.
- lt_i is sampled only at the accept edge. Later changes have no effect on the operation in flight.
- Reset asserted mid-operation aborts it with no ack. All state returns to the reset values.
- full_t rises on the ack edge of the W-th successful enq. empty_t rises on the ack edge of the deq that removes the last entry.

## Test plan
- Reset, then idle 10 cycles -> empty_t = 1, full_t = 0, rdy_t = 1, lt_o = 0, no acks.
- Enq keys 5, 10, 3, 20, 2, 12, 27, 8 (W = 8), one per ≥2 cycles -> eight enq_o pulses; lt_o ends at 2; full_t = 1 after the 8th; contents 2,3,5,8,10,12,20,27.
- On the full queue, repl keys 9, 4, 15, 30 -> repl_o each time; rt_o = 2, 3, 4, 5 in turn; full_t stays 1; final contents 8,9,10,12,15,20,27,30; lt_o = 8.
- Eight deqs with gaps of 9 down to 2 cycles -> rt_o = 8, 9, 10, 12, 15, 20, 27, 30; full_t falls after the first; empty_t = 1 and lt_o = 0 after the last.
- Enq when full, deq when empty, or a command while rdy_t = 0 -> no ack; contents, rt_o and flags unchanged.
- Enq 7 (val 1), then enq 7 (val 2), then deq twice -> rt_o.val = 1, then 2. Also: enq+deq asserted together on a non-empty queue -> only deq executes.

Source files
------------

// File: rtl/quickq_top.sv
// QuickQ: sorted-array priority queue. The minimum key is always at e[0];
// one enqueue, dequeue or replace runs per two-cycle accept/apply handshake.
package pq_pkg;
    typedef struct packed {
        logic [15:0] val;
        logic [15:0] key;
    } kv_t;
endpackage

module quickq_top
    import pq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enq,
    input  logic deq,
    input  logic repl,
    input  kv_t  lt_i,
    input  kv_t  rt_i,
    output kv_t  lt_o,
    output kv_t  rt_o,
    output logic enq_o,
    output logic deq_o,
    output logic repl_o,
    output logic full_t,
    output logic empty_t,
    output logic rdy_t
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    kv_t            e_reg [W];
    kv_t            e_next [W];
    kv_t            base [W];
    kv_t            ins [W];
    logic [W-1:0]   le;
    logic [CW-1:0]  count_reg, count_next, base_cnt;
    logic           enq_cmd_reg, deq_cmd_reg, repl_cmd_reg;
    kv_t            lt_reg;
    logic           busy, remove, do_enq, do_deq, do_repl;
    logic           unused_rt;

    assign unused_rt = &{1'b0, rt_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        rdy_t      = 1'b0;
        case (state_reg)
            IDLE: begin
                rdy_t = 1'b1;
                if (enq || deq || repl) state_next = BUSY;
            end
            BUSY:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == BUSY);
    assign remove  = repl_cmd_reg | deq_cmd_reg;
    assign do_repl = busy & repl_cmd_reg & (count_reg != '0);
    assign do_deq  = busy & deq_cmd_reg  & (count_reg != '0);
    assign do_enq  = busy & enq_cmd_reg  & (count_reg != CW'(W));
    assign base_cnt = remove ? count_reg - 1'b1 : count_reg;

    // base is the array after an optional head removal; the new entry goes
    // right after the prefix of base entries whose key is <= the new key.
    for (genvar gi = 0; gi < W; gi++) begin : g_entry
        if (gi < W - 1) begin : g_shift
            assign base[gi] = remove ? e_reg[gi+1] : e_reg[gi];
        end else begin : g_last
            assign base[gi] = remove ? '0 : e_reg[gi];
        end

        assign le[gi] = (CW'(gi) < base_cnt) && (base[gi].key <= lt_reg.key);

        if (gi == 0) begin : g_ins0
            assign ins[gi] = le[gi] ? base[gi] : lt_reg;
        end else begin : g_insn
            assign ins[gi] = le[gi]   ? base[gi]   :
                             le[gi-1] ? lt_reg     : base[gi-1];
        end

        assign e_next[gi] = (do_enq | do_repl) ? ins[gi]  :
                            do_deq             ? base[gi] : e_reg[gi];
    end

    always_comb begin
        count_next = count_reg;
        if (do_enq)      count_next = count_reg + 1'b1;
        else if (do_deq) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < W; i++) e_reg[i] <= '0;
            count_reg    <= '0;
            enq_cmd_reg  <= 1'b0;
            deq_cmd_reg  <= 1'b0;
            repl_cmd_reg <= 1'b0;
            lt_reg       <= '0;
            lt_o         <= '0;
            rt_o         <= '0;
            enq_o        <= 1'b0;
            deq_o        <= 1'b0;
            repl_o       <= 1'b0;
            full_t       <= 1'b0;
            empty_t      <= 1'b1;
        end else begin
            if (state_reg == IDLE && (enq || deq || repl)) begin
                repl_cmd_reg <= repl;
                deq_cmd_reg  <= deq & ~repl;
                enq_cmd_reg  <= enq & ~deq & ~repl;
                lt_reg       <= lt_i;
            end
            for (int i = 0; i < W; i++) e_reg[i] <= e_next[i];
            count_reg <= count_next;
            if (do_deq || do_repl) rt_o <= e_reg[0];
            lt_o    <= e_next[0];
            full_t  <= (count_next == CW'(W));
            empty_t <= (count_next == '0);
            enq_o   <= do_enq;
            deq_o   <= do_deq;
            repl_o  <= do_repl;
        end
    end
endmodule

// File: tb/tb_quickq_top.sv
// Bench for quickq_top: directed steps plus random commands against a sorted-queue model.
module tb_quickq_top;
    import pq_pkg::*;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic enq, deq, repl;
    kv_t  lt_i, rt_i, lt_o, rt_o;
    logic enq_o, deq_o, repl_o, full_t, empty_t, rdy_t;

    quickq_top #(.W(W)) dut (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .repl(repl),
        .lt_i(lt_i), .rt_i(rt_i), .lt_o(lt_o), .rt_o(rt_o),
        .enq_o(enq_o), .deq_o(deq_o), .repl_o(repl_o),
        .full_t(full_t), .empty_t(empty_t), .rdy_t(rdy_t)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    kv_t  mq[$];
    kv_t  m_rt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_ins(kv_t x);
        int p = 0;
        while (p < mq.size() && mq[p].key <= x.key) p++;
        mq.insert(p, x);
    endfunction

    task automatic check_state(string tag);
        kv_t head;
        head = (mq.size() > 0) ? mq[0] : kv_t'(0);
        chk({tag, " lt_o"}, lt_o, head);
        chk({tag, " rt_o"}, rt_o, m_rt);
        chk({tag, " full"}, 32'(full_t), 32'(mq.size() == W));
        chk({tag, " empty"}, 32'(empty_t), 32'(mq.size() == 0));
    endtask

    // Called at a falling edge with the DUT idle. junk drives random commands
    // during the busy cycle, which must be ignored.
    task automatic op(bit e, bit d, bit r, kv_t x, bit junk, int gap);
        bit ea, ed, er;
        string tag;
        tag = $sformatf("op e%0b d%0b r%0b key%0d", e, d, r, x.key);
        chk({tag, " rdy_pre"}, 32'(rdy_t), 32'd1);
        enq = e; deq = d; repl = r; lt_i = x; rt_i = $urandom;
        @(posedge clk); #1;
        chk({tag, " rdy_busy"}, 32'(rdy_t), 32'd0);
        chk({tag, " ack_busy"}, {29'd0, enq_o, deq_o, repl_o}, 32'd0);
        lt_i = $urandom;
        if (junk) begin
            enq = 1'b1; deq = $urandom_range(0, 1); repl = $urandom_range(0, 1);
        end else begin
            enq = 1'b0; deq = 1'b0; repl = 1'b0;
        end
        @(posedge clk); #1;
        enq = 1'b0; deq = 1'b0; repl = 1'b0;
        ea = 0; ed = 0; er = 0;
        if (r) begin
            if (mq.size() > 0) begin er = 1; m_rt = mq.pop_front(); m_ins(x); end
        end else if (d) begin
            if (mq.size() > 0) begin ed = 1; m_rt = mq.pop_front(); end
        end else if (e) begin
            if (mq.size() < W) begin ea = 1; m_ins(x); end
        end
        $display("op enq=%0b deq=%0b repl=%0b key=%0d val=%0d size=%0d rt=%h lt=%h",
                 e, d, r, x.key, x.val, mq.size(), rt_o, lt_o);
        chk({tag, " acks"}, {29'd0, enq_o, deq_o, repl_o}, {29'd0, ea, ed, er});
        chk({tag, " rdy_post"}, 32'(rdy_t), 32'd1);
        check_state(tag);
        if (gap > 0) begin
            @(posedge clk); #1;
            chk({tag, " ack_clear"}, {29'd0, enq_o, deq_o, repl_o}, 32'd0);
            repeat (gap - 1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    function automatic kv_t mk(int k, int v);
        kv_t t;
        t.key = 16'(k);
        t.val = 16'(v);
        return t;
    endfunction

    initial begin
        int enq_keys[8]  = '{5, 10, 3, 20, 2, 12, 27, 8};
        int repl_keys[4] = '{9, 4, 15, 30};
        int repl_rt[4]   = '{2, 3, 4, 5};
        int deq_rt[8]    = '{8, 9, 10, 12, 15, 20, 27, 30};
        rst = 1'b0; enq = 0; deq = 0; repl = 0; lt_i = '0; rt_i = '0; m_rt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("reset idle acks", {29'd0, enq_o, deq_o, repl_o}, 32'd0);
            chk("reset idle rdy", 32'(rdy_t), 32'd1);
        end
        check_state("reset");
        @(negedge clk);

        foreach (enq_keys[i]) op(1, 0, 0, mk(enq_keys[i], i), 0, 1);
        chk("full head key", 32'(lt_o.key), 32'd2);
        chk("full flag", 32'(full_t), 32'd1);
        op(1, 0, 0, mk(1, 99), 0, 1);     // enq when full: dropped
        foreach (repl_keys[i]) begin
            op(0, 0, 1, mk(repl_keys[i], 40 + i), i[0], 1);
            chk("repl rt key", 32'(rt_o.key), 32'(repl_rt[i]));
        end
        chk("repl head key", 32'(lt_o.key), 32'd8);
        foreach (deq_rt[i]) begin
            op(0, 1, 0, mk(0, 0), 0, 9 - i);
            chk("deq rt key", 32'(rt_o.key), 32'(deq_rt[i]));
        end
        chk("drained empty", 32'(empty_t), 32'd1);
        op(0, 1, 0, mk(0, 0), 0, 1);      // deq when empty
        op(0, 0, 1, mk(6, 6), 0, 1);      // repl when empty

        op(1, 0, 0, mk(7, 1), 0, 0);
        op(1, 0, 0, mk(7, 2), 1, 0);
        op(0, 1, 0, mk(0, 0), 0, 0);
        chk("fifo tie 1", 32'(rt_o.val), 32'd1);
        op(1, 1, 0, mk(3, 3), 0, 1);      // enq+deq: only deq
        chk("fifo tie 2", 32'(rt_o.val), 32'd2);
        chk("enq+deq empty", 32'(empty_t), 32'd1);

        op(1, 0, 0, mk(11, 11), 0, 1);
        enq = 1'b1; lt_i = mk(1, 1);
        @(posedge clk); #1;
        rst = 1'b0; enq = 1'b0; #2;
        mq.delete(); m_rt = '0;
        chk("abort rdy", 32'(rdy_t), 32'd1);
        check_state("abort");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort acks", {29'd0, enq_o, deq_o, repl_o}, 32'd0);
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            int sel;
            bit e, d, r;
            sel = $urandom_range(0, 9);
            e = (sel < 5) || ($urandom_range(0, 3) == 0);
            d = (sel >= 5 && sel < 8) || ($urandom_range(0, 5) == 0);
            r = (sel >= 8) || ($urandom_range(0, 7) == 0);
            op(e, d, r, mk($urandom_range(0, 15), $urandom_range(0, 65535)),
               $urandom_range(0, 1), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
